// File: rtl/spi_sensor_pkg.sv
// Shared definitions for the sensor SPI scheduler: frame opcodes, the
// dummy frame, tag-pipe entry layout and the frame builder.
package spi_sensor_pkg;

    localparam int CH_W = 6;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    // READ of register 63: harmless frame used to clock results out
    localparam logic [15:0] DUMMY_FRAME = 16'hFF00;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_SWEEP = 2'd1,
        KIND_HOST  = 2'd2
    } tag_kind_t;

    typedef struct packed {
        logic            valid;
        tag_kind_t       kind;
        logic [CH_W-1:0] ch;
    } tag_t;

    function automatic logic [15:0] build_frame(input logic [1:0]      op,
                                                input logic [CH_W-1:0] addr,
                                                input logic [7:0]      data);
        return {op, addr, data};
    endfunction

endpackage

// File: rtl/spi_tag_pipe.sv
// Tag pipe: remembers what each in-flight frame was, so the word that comes
// back two frames later can be routed. stage0/stage1 hold the two newest
// frames; head holds the frame whose result arrives with the current spi_done.
module spi_tag_pipe
    import spi_sensor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    input  logic flush,
    output tag_t pop_tag
);

    tag_t stage0, stage1, head;

    // Shift on push; the entry falling out of stage1 becomes the head to pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage0 <= '0;
            stage1 <= '0;
            head   <= '0;
        end else if (flush) begin
            stage0 <= '0;
            stage1 <= '0;
            head   <= '0;
        end else if (push) begin
            head   <= stage1;
            stage1 <= stage0;
            stage0 <= push_tag;
        end else if (pop) begin
            head.valid <= 1'b0;
        end
    end

    assign pop_tag = head;

endmodule

// File: rtl/spi_sample_scheduler.sv
// Arbitrates the sensor SPI master between the periodic channel sweep and
// the host register port, and routes delayed results via the tag pipe.
module spi_sample_scheduler
    import spi_sensor_pkg::*;
#(
    parameter int N_CH          = 32,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_req,
    input  logic            host_wr,
    input  logic [CH_W-1:0] host_addr,
    input  logic [7:0]      host_wdata,
    output logic            host_ack,
    output logic [15:0]     host_rdata,
    output logic            spi_start,
    output logic [15:0]     spi_tx,
    input  logic            spi_busy,
    input  logic            spi_done,
    input  logic [15:0]     spi_rx,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic [15:0]     res_data,
    output logic            sweep_active,
    output logic            overrun
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int IDX_W = 7;
    localparam logic [CNT_W-1:0] TICK_AT    = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0] CONV_END   = IDX_W'(N_CH);
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(N_CH + 1);
    localparam logic [IDX_W-1:0] HOST_LAST  = IDX_W'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick, sweep_pending, mode_sweep;
    logic [IDX_W-1:0] frame_idx, idx_next;
    logic             take_sweep, take_host, done_ok, last_frame, in_sweep;
    logic [15:0]      host_frame, next_frame;
    tag_t             push_tag, pop_tag;

    assign tick       = (tick_cnt == TICK_AT);
    // A tick in the same IDLE cycle as host_req still wins arbitration
    assign take_sweep = (state == S_IDLE) && (sweep_pending || tick);
    // host_req is still high during the ack cycle; do not restart on it
    assign take_host  = (state == S_IDLE) && !take_sweep && host_req && !host_ack;
    assign done_ok    = (state == S_WAIT) && spi_done;
    assign last_frame = (frame_idx == (mode_sweep ? SWEEP_LAST : HOST_LAST));
    assign in_sweep   = sweep_active || ((state != S_IDLE) && mode_sweep);
    assign spi_start  = (state == S_ISSUE) && !spi_busy;
    assign idx_next   = frame_idx + IDX_W'(1);
    assign host_frame = host_wr ? build_frame(OP_WRITE, host_addr, host_wdata)
                                : build_frame(OP_READ,  host_addr, 8'h00);

    // Frame following the one just completed
    always_comb begin
        next_frame = DUMMY_FRAME;
        if (mode_sweep && (idx_next < CONV_END))
            next_frame = build_frame(OP_CONVERT, idx_next[CH_W-1:0], 8'h00);
    end

    // Tag describing the frame being started
    always_comb begin
        push_tag       = '0;
        push_tag.valid = 1'b1;
        push_tag.kind  = KIND_NONE;
        if (mode_sweep && (frame_idx < CONV_END)) begin
            push_tag.kind = KIND_SWEEP;
            push_tag.ch   = frame_idx[CH_W-1:0];
        end else if (!mode_sweep && (frame_idx == '0)) begin
            push_tag.kind = KIND_HOST;
        end
    end

    // Free-running sweep tick counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    // Frame sequencer: selects a transaction in IDLE and walks its frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_sweep <= 1'b0;
            frame_idx  <= '0;
            spi_tx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_sweep) begin
                        mode_sweep <= 1'b1;
                        frame_idx  <= '0;
                        spi_tx     <= build_frame(OP_CONVERT, '0, 8'h00);
                        state      <= S_ISSUE;
                    end else if (take_host) begin
                        mode_sweep <= 1'b0;
                        frame_idx  <= '0;
                        spi_tx     <= host_frame;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: if (!spi_busy) state <= S_WAIT;
                S_WAIT: begin
                    if (spi_done) begin
                        if (last_frame) begin
                            state <= S_IDLE;
                        end else begin
                            frame_idx <= idx_next;
                            spi_tx    <= next_frame;
                            state     <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sweep bookkeeping: pending request, activity window, sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_pending <= 1'b0;
            sweep_active  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (tick && in_sweep)
                overrun <= 1'b1;
            if (take_sweep)
                sweep_pending <= 1'b0;
            else if (tick && !in_sweep)
                sweep_pending <= 1'b1;
            if (spi_start && mode_sweep && (frame_idx == '0))
                sweep_active <= 1'b1;
            else if (done_ok && last_frame && mode_sweep)
                sweep_active <= 1'b0;
        end
    end

    // Route each returning word according to the tag of its frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_data   <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            res_valid <= 1'b0;
            host_ack  <= 1'b0;
            if (done_ok && pop_tag.valid) begin
                case (pop_tag.kind)
                    KIND_SWEEP: begin
                        res_valid <= 1'b1;
                        res_ch    <= pop_tag.ch;
                        res_data  <= spi_rx;
                    end
                    KIND_HOST: begin
                        host_ack   <= 1'b1;
                        host_rdata <= spi_rx;
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_tag_pipe u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push     (spi_start),
        .push_tag (push_tag),
        .pop      (done_ok),
        .flush    (done_ok && last_frame),
        .pop_tag  (pop_tag)
    );

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed bench for spi_sample_scheduler: a behavioural SPI master per
// instance, instance a (N_CH=4, period 200) for the main scenarios and
// instance b (N_CH=4, period 50) for overrun.
module tb_spi_sample_scheduler;

    localparam int LIMIT = 600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b;
    logic        host_req, host_wr;
    logic [5:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        spi_start, spi_busy, spi_done;
    logic [15:0] spi_tx, spi_rx;
    logic        res_valid, sweep_active, overrun;
    logic [5:0]  res_ch;
    logic [15:0] res_data;
    logic        force_busy;

    logic        b_host_ack, b_spi_start, b_res_valid, b_sweep_active, b_overrun;
    logic [15:0] b_host_rdata, b_spi_tx, b_res_data;
    logic [5:0]  b_res_ch;

    // SPI master models: busy 17 clk after start, rx = tx of two frames back
    logic [1:0]       m_busy = '0, m_done = '0, m_start;
    logic [1:0][4:0]  m_cnt  = '0;
    logic [1:0][15:0] m_cur = '0, m_p1 = '0, m_p2 = '0, m_rx = '0, m_tx;

    assign m_start = {b_spi_start, spi_start};
    assign m_tx    = {b_spi_tx, spi_tx};
    assign spi_busy = m_busy[0] | force_busy;
    assign spi_done = m_done[0];
    assign spi_rx   = m_rx[0];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_done[k] <= 1'b0;
            if (m_start[k]) begin
                m_busy[k] <= 1'b1;
                m_cnt[k]  <= 5'd17;
                m_p2[k]   <= m_p1[k];
                m_p1[k]   <= m_cur[k];
                m_cur[k]  <= m_tx[k];
            end else if (m_busy[k]) begin
                m_cnt[k] <= m_cnt[k] - 5'd1;
                if (m_cnt[k] == 5'd1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_rx[k]   <= m_p2[k];
                end
            end
        end
    end

    spi_sample_scheduler #(.N_CH(4), .SAMPLE_PERIOD(200)) dut (
        .clk(clk), .reset(rst),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .sweep_active(sweep_active), .overrun(overrun)
    );

    spi_sample_scheduler #(.N_CH(4), .SAMPLE_PERIOD(50)) dut_b (
        .clk(clk), .reset(rst_b),
        .host_req(1'b0), .host_wr(1'b0), .host_addr(6'd0), .host_wdata(8'd0),
        .host_ack(b_host_ack), .host_rdata(b_host_rdata),
        .spi_start(b_spi_start), .spi_tx(b_spi_tx), .spi_busy(m_busy[1]), .spi_done(m_done[1]), .spi_rx(m_rx[1]),
        .res_valid(b_res_valid), .res_ch(b_res_ch), .res_data(b_res_data),
        .sweep_active(b_sweep_active), .overrun(b_overrun)
    );

    // Independent tick reference for instance a: tick while count is 199
    int tb_cnt;
    always @(posedge clk or posedge rst)
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 199) ? 0 : tb_cnt + 1;

    // Traffic logs, sampled on the falling edge
    logic [15:0] tx_log[$];
    logic [5:0]  ch_log[$], b_ch_log[$];
    logic [15:0] dat_log[$], b_dat_log[$];
    int          ack_cnt = 0;

    always @(negedge clk) begin
        if (spi_start) tx_log.push_back(spi_tx);
        if (res_valid) begin ch_log.push_back(res_ch); dat_log.push_back(res_data); end
        if (b_res_valid) begin b_ch_log.push_back(b_res_ch); b_dat_log.push_back(b_res_data); end
        if (host_ack) ack_cnt++;
    end

    int n_vec = 0, n_err = 0;
    logic [15:0] sweep_tx [6] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'hFF00};
    logic [15:0] sweep_res [4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input int n, input string tag);
        int c = 0;
        while (tx_log.size() < n && c < LIMIT) begin @(negedge clk); c++; end
        check(tag, 32'(tx_log.size() >= n), 1);
    endtask

    task automatic wait_res(input int n, input string tag);
        int c = 0;
        while (ch_log.size() < n && c < LIMIT) begin @(negedge clk); c++; end
        check(tag, 32'(ch_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (sweep_active && c < LIMIT) begin @(negedge clk); c++; end
        check(tag, 32'(sweep_active), 0);
    endtask

    task automatic wait_tick(input string tag);
        int c = 0;
        while (tb_cnt != 199 && c < LIMIT) begin @(negedge clk); c++; end
        check(tag, 32'(tb_cnt == 199), 1);
    endtask

    task automatic wait_ack(input string tag);
        int c = 0;
        while (!host_ack && c < LIMIT) begin @(negedge clk); c++; end
        check(tag, 32'(host_ack), 1);
    endtask

    task automatic check_sweep(input int tb, input int rb, input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[tb+i]), 32'(sweep_tx[i]));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_ch%0d", tag, i), 32'(ch_log[rb+i]), i);
            check($sformatf("%s_dat%0d", tag, i), 32'(dat_log[rb+i]), 32'(sweep_res[i]));
        end
    endtask

    initial begin
        int tb, rb, ab, seen;
        rst = 1'b1; rst_b = 1'b1; force_busy = 1'b0;
        host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_spi_start", 32'(spi_start), 0);
        check("rst_spi_tx", 32'(spi_tx), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_sweep_active", 32'(sweep_active), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_b_overrun", 32'(b_overrun), 0);
        rst = 1'b0; rst_b = 1'b0;

        // 1) plain sweep
        wait_tx(3, "t1_wait_tx");
        check("t1_active_mid", 32'(sweep_active), 1);
        wait_idle("t1_idle");
        wait_res(4, "t1_wait_res");
        check_sweep(0, 0, "t1");
        check("t1_overrun", 32'(overrun), 0);
        check("t4_b_overrun_set", 32'(b_overrun), 1);

        // 2) host WRITE addr 5 data A5
        tb = tx_log.size(); ab = ack_cnt;
        host_wr = 1'b1; host_addr = 6'd5; host_wdata = 8'hA5; host_req = 1'b1;
        wait_ack("t2_wait_ack");
        check("t2_rdata", 32'(host_rdata), 32'h85A5);
        host_req = 1'b0;
        check("t2_tx0", 32'(tx_log[tb]), 32'h85A5);
        check("t2_tx1", 32'(tx_log[tb+1]), 32'hFF00);
        check("t2_tx2", 32'(tx_log[tb+2]), 32'hFF00);
        repeat (20) @(negedge clk);
        check("t2_ack_once", 32'(ack_cnt - ab), 1);

        // 3) host READ addr 3 arriving in the tick cycle: sweep goes first
        wait_idle("t3_idle0");
        wait_tick("t3_wait_tick");
        tb = tx_log.size(); rb = ch_log.size();
        host_wr = 1'b0; host_addr = 6'd3; host_req = 1'b1;
        wait_ack("t3_wait_ack");
        check("t3_rdata", 32'(host_rdata), 32'hC300);
        host_req = 1'b0;
        check_sweep(tb, rb, "t3");
        check("t3_host_tx0", 32'(tx_log[tb+6]), 32'hC300);
        check("t3_host_tx1", 32'(tx_log[tb+7]), 32'hFF00);
        check("t3_host_tx2", 32'(tx_log[tb+8]), 32'hFF00);
        check("t3_overrun", 32'(overrun), 0);

        // 6) spi_busy held for 10 cycles while a frame is waiting to issue
        wait_tick("t6_wait_tick");
        tb = tx_log.size(); rb = ch_log.size();
        wait_tx(tb + 2, "t6_wait_tx");
        seen = 0;
        while (!spi_done && seen < LIMIT) begin @(negedge clk); seen++; end
        check("t6_saw_done", 32'(spi_done), 1);
        force_busy = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge clk); if (spi_start) seen++; end
        check("t6_no_start_busy", seen, 0);
        force_busy = 1'b0;
        #1;
        check("t6_start_on_release", 32'(spi_start), 1);
        wait_idle("t6_idle");
        wait_res(rb + 4, "t6_wait_res");
        check_sweep(tb, rb, "t6");

        // 5) asynchronous reset mid-sweep
        wait_tick("t5_wait_tick");
        tb = tx_log.size();
        wait_tx(tb + 3, "t5_wait_tx");
        @(negedge clk); #2;
        check("t5_active_before", 32'(sweep_active), 1);
        rst = 1'b1;
        #1;
        check("t5_async_spi_tx", 32'(spi_tx), 0);
        check("t5_async_start", 32'(spi_start), 0);
        check("t5_async_active", 32'(sweep_active), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tb = tx_log.size(); rb = ch_log.size();
        repeat (150) @(negedge clk);
        check("t5_no_res_after", ch_log.size() - rb, 0);
        check("t5_no_start_after", tx_log.size() - tb, 0);
        wait_tick("t5_wait_tick2");
        wait_tx(tb + 6, "t5_wait_tx2");
        wait_idle("t5_idle");
        wait_res(rb + 4, "t5_wait_res");
        check_sweep(tb, rb, "t5");

        // 4) short period instance: sticky overrun, first sweep intact
        check("t4_b_overrun_stays", 32'(b_overrun), 1);
        check("t4_b_nres", 32'(b_ch_log.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_b_ch%0d", i), 32'(b_ch_log[i]), i);
            check($sformatf("t4_b_dat%0d", i), 32'(b_dat_log[i]), 32'(sweep_res[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
